// File: rtl/led_pkg.sv
// Shared types and constants for the 16x16 bicolour LED matrix scanner.
package led_pkg;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned COLS  = 16;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY
  } state_e;

endpackage

// File: rtl/led_matrix_scan_sclk_tick.sv
// Half-period tick generator for the column shift clock; counts only while enabled.
module sclk_tick #(
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter parks at zero when disabled so every SHIFT starts on a fresh half-period.
  always_comb begin
    cnt_d  = '0;
    tick_c = 1'b0;
    if (en) begin
      if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanned 16x16 red/green LED matrix driver with a double-buffered frame store.
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned DWELL    = 256
) (
  input  logic            clk,
  input  logic            RST,
  input  frame_t          RedPixels,
  input  frame_t          GrnPixels,
  input  logic            frame_valid,
  output logic            frame_ready,
  output logic            red_sd,
  output logic            grn_sd,
  output logic            sclk,
  output logic            latch,
  output logic            oe_n,
  output logic [ROWS-1:0] row_en
);

  localparam int unsigned DW_W   = 16;
  localparam int unsigned HALF_W = COL_W + 1;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic               full_q, full_d;
  frame_t             shadow_r_q, shadow_r_d, shadow_g_q, shadow_g_d;
  frame_t             active_r_q, active_r_d, active_g_q, active_g_d;
  logic               frame_ready_q, frame_ready_d;
  logic               red_sd_q, red_sd_d, grn_sd_q, grn_sd_d;
  logic               sclk_q, sclk_d, latch_q, latch_d, oe_n_q, oe_n_d;
  logic [ROWS-1:0]    row_en_q, row_en_d;
  logic [COL_W-1:0]   col;
  logic               tick_c;

  sclk_tick #(.SCLK_DIV(SCLK_DIV)) u_sclk_tick (
    .clk    (clk),
    .rst_n  (RST),
    .en     (state_q == SHIFT),
    .tick_c (tick_c)
  );

  // Next state, buffer handoff, and outputs derived from the next state so they align with it.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    half_d     = half_q;
    dwell_d    = dwell_q;
    full_d     = full_q;
    shadow_r_d = shadow_r_q;
    shadow_g_d = shadow_g_q;
    active_r_d = active_r_q;
    active_g_d = active_g_q;

    if (frame_valid && !full_q) begin
      shadow_r_d = RedPixels;
      shadow_g_d = GrnPixels;
      full_d     = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (full_q) begin
          active_r_d = shadow_r_q;
          active_g_d = shadow_g_q;
          full_d     = 1'b0;
          row_d      = '0;
          half_d     = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          half_d = half_q + HALF_W'(1);
          if (half_q == HALF_W'(2 * COLS - 1)) state_d = LATCH;
        end
      end
      LATCH: begin
        dwell_d = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (dwell_q == DW_W'(DWELL - 1)) begin
          state_d = SHIFT;
          half_d  = '0;
          row_d   = row_q + ROW_W'(1);
          // Frame boundary: the only point where the active buffer may change.
          if (row_q == ROW_W'(ROWS - 1) && full_q) begin
            active_r_d = shadow_r_q;
            active_g_d = shadow_g_q;
            full_d     = 1'b0;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    col           = COL_W'(COLS - 1) - half_d[HALF_W-1:1];
    frame_ready_d = !full_d;
    sclk_d        = (state_d == SHIFT) && half_d[0];
    red_sd_d      = (state_d == SHIFT) && active_r_d[row_d][col];
    grn_sd_d      = (state_d == SHIFT) && active_g_d[row_d][col];
    latch_d       = (state_d == LATCH);
    oe_n_d        = (state_d != DISPLAY);
    row_en_d      = (state_d == DISPLAY) ? (ROWS'(1) << row_d) : '0;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      row_q         <= '0;
      half_q        <= '0;
      dwell_q       <= '0;
      full_q        <= 1'b0;
      shadow_r_q    <= '0;
      shadow_g_q    <= '0;
      active_r_q    <= '0;
      active_g_q    <= '0;
      frame_ready_q <= 1'b1;
      red_sd_q      <= 1'b0;
      grn_sd_q      <= 1'b0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      row_en_q      <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      half_q        <= half_d;
      dwell_q       <= dwell_d;
      full_q        <= full_d;
      shadow_r_q    <= shadow_r_d;
      shadow_g_q    <= shadow_g_d;
      active_r_q    <= active_r_d;
      active_g_q    <= active_g_d;
      frame_ready_q <= frame_ready_d;
      red_sd_q      <= red_sd_d;
      grn_sd_q      <= grn_sd_d;
      sclk_q        <= sclk_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      row_en_q      <= row_en_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign red_sd      = red_sd_q;
  assign grn_sd      = grn_sd_q;
  assign sclk        = sclk_q;
  assign latch       = latch_q;
  assign oe_n        = oe_n_q;
  assign row_en      = row_en_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: timeline model of scan outputs plus directed frame scenarios.
module tb_led_matrix_scan;
  import led_pkg::*;

  localparam int SD = 1;
  localparam int DW = 4;
  localparam int P  = 32 * SD + 1 + DW;
  localparam int FP = 16 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  frame_t      red_in = '0;
  frame_t      grn_in = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready, red_sd, grn_sd, sclk, latch, oe_n;
  logic [15:0] row_en;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  led_matrix_scan #(.SCLK_DIV(SD), .DWELL(DW)) dut (
    .clk(clk), .RST(rst_n), .RedPixels(red_in), .GrnPixels(grn_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .red_sd(red_sd),
    .grn_sd(grn_sd), .sclk(sclk), .latch(latch), .oe_n(oe_n), .row_en(row_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the scan is a pure function of the time since the first frame started.
  bit     m_run = 1'b0;
  int     m_t = 0;
  bit     m_full = 1'b0;
  bit     m_nf;
  frame_t m_sh_r = '0, m_sh_g = '0, m_ac_r = '0, m_ac_g = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_full = 1'b0;
      m_sh_r = '0; m_sh_g = '0; m_ac_r = '0; m_ac_g = '0;
    end else begin
      m_nf = m_full;
      if (!m_run) begin
        if (m_full) begin
          m_ac_r = m_sh_r; m_ac_g = m_sh_g; m_nf = 1'b0; m_run = 1'b1; m_t = 0;
        end
      end else if (m_t == FP - 1) begin
        m_t = 0;
        if (m_full) begin m_ac_r = m_sh_r; m_ac_g = m_sh_g; m_nf = 1'b0; end
      end else begin
        m_t = m_t + 1;
      end
      if (frame_valid && !m_full) begin m_sh_r = red_in; m_sh_g = grn_in; m_nf = 1'b1; end
      m_full = m_nf;
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    int r, o;
    bit sh, dp;
    @(negedge clk);
    if (chk_en) begin
      chk("frame_ready", frame_ready, !m_full);
      if (!m_run) begin
        chk("idle_oe_n", oe_n, 1); chk("idle_row_en", row_en, 0);
        chk("idle_sclk", sclk, 0); chk("idle_latch", latch, 0);
        chk("idle_red_sd", red_sd, 0); chk("idle_grn_sd", grn_sd, 0);
      end else begin
        r = m_t / P; o = m_t % P;
        sh = (o < 32 * SD); dp = (o > 32 * SD);
        chk("sclk", sclk, sh ? (o / SD) % 2 : 0);
        chk("latch", latch, o == 32 * SD);
        chk("oe_n", oe_n, !dp);
        chk("row_en", row_en, dp ? (16'(1) << r) : 16'h0);
        if (sh) begin
          chk("red_sd", red_sd, m_ac_r[r][15 - o / (2 * SD)]);
          chk("grn_sd", grn_sd, m_ac_g[r][15 - o / (2 * SD)]);
        end
      end
    end
  end

  // Log of each row's display start, for spacing checks.
  int          cyc = 0;
  int          log_t[$];
  logic [15:0] log_v[$];
  initial begin
    logic [15:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (row_en != 16'h0 && prev == 16'h0) begin log_t.push_back(cyc); log_v.push_back(row_en); end
      prev = row_en;
    end
  end

  task automatic offer();
    @(negedge clk); frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
  endtask

  task automatic set_frame(input logic [3:0] tag);
    for (int r = 0; r < 16; r++) begin
      red_in[r] = {tag, 4'(r), 8'h5A};
      grn_in[r] = {4'(r), tag, 8'hC3};
    end
  endtask

  task automatic wait_row_en(input logic [15:0] v, input string name);
    int k = 0;
    while (row_en !== v && k < 2000) begin @(negedge clk); k++; end
    if (row_en !== v) begin
      n_tests++; n_fail++;
      $display("FAIL %s: row_en=%0h never reached %0h", name, row_en, v);
    end
  endtask

  task automatic capture_row(input string name, output logic [15:0] rw, output logic [15:0] gw);
    logic p;
    int n = 0, k = 0;
    rw = '0; gw = '0; p = sclk;
    while (n < 16 && k < 2000) begin
      @(negedge clk); k++;
      if (sclk && !p) begin rw = {rw[14:0], red_sd}; gw = {gw[14:0], grn_sd}; n++; end
      p = sclk;
    end
    if (n < 16) begin
      n_tests++; n_fail++;
      $display("FAIL %s: only %0d sclk rises seen", name, n);
    end
  endtask

  initial begin
    logic [15:0] rw, gw;
    int lc, rc, k;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Idle after reset with no frame offered.
    repeat (100) @(negedge clk);
    chk("idle_oe_n_lit", oe_n, 1);
    chk("idle_row_en_lit", row_en, 0);
    chk("idle_sclk_lit", sclk, 0);
    chk("idle_ready_lit", frame_ready, 1);

    // First frame: only row 0 red has the two edge columns lit.
    log_t.delete(); log_v.delete();
    red_in = '0; grn_in = '0; red_in[0] = 16'h8001;
    offer();
    capture_row("f1_cap", rw, gw);
    chk("f1_row0_red", rw, 16'h8001);
    chk("f1_row0_grn", gw, 16'h0000);
    lc = 0; rc = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (latch) lc++;
      if (row_en == 16'h0001) rc++;
    end
    chk("f1_latch_pulses", lc, 1);
    chk("f1_row0_dwell", rc, 4);

    // Full-frame row stepping and wrap.
    k = 0;
    while (log_t.size() < 17 && k < 1500) begin @(negedge clk); k++; end
    chk("row_log_len", log_t.size() >= 17, 1);
    if (log_t.size() >= 17) begin
      for (int i = 0; i < 17; i++) begin
        chk("row_step_val", log_v[i], 16'(1) << (i % 16));
        chk("row_step_time", log_t[i] - log_t[0], 37 * i);
      end
      chk("frame_wrap", log_t[16] - log_t[0], 592);
    end

    // Frame A, then B accepted mid-frame, then C offered while B pending.
    set_frame(4'hA);
    offer();
    wait_row_en(16'h8000, "wait_f1_end");
    wait_row_en(16'h0020, "wait_a_row5");
    set_frame(4'hB);
    offer();
    chk("b_ready_low", frame_ready, 0);
    set_frame(4'hC);
    offer();
    chk("c_ready_low", frame_ready, 0);
    wait_row_en(16'h0100, "wait_a_row8");
    capture_row("a9_cap", rw, gw);
    chk("a_row9_red", rw, 16'hA95A);
    chk("a_row9_grn", gw, 16'h9AC3);
    wait_row_en(16'h8000, "wait_a_end");
    capture_row("b0_cap", rw, gw);
    chk("b_row0_red", rw, 16'hB05A);
    chk("b_row0_grn", gw, 16'h0BC3);
    chk("ready_after_b", frame_ready, 1);
    wait_row_en(16'h8000, "wait_b_end");
    capture_row("b0_again_cap", rw, gw);
    chk("b_again_row0_red", rw, 16'hB05A);

    // Asynchronous reset during row 7 display.
    wait_row_en(16'h0080, "wait_row7");
    #2 rst_n = 1'b0;
    #1;
    chk("async_oe_n", oe_n, 1);
    chk("async_row_en", row_en, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_oe_n", oe_n, 1);
    chk("post_rst_ready", frame_ready, 1);
    set_frame(4'hD);
    offer();
    capture_row("d0_cap", rw, gw);
    chk("d_row0_red", rw, 16'hD05A);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
